// File: rtl/operand_fwd_ctrl.sv
// operand_fwd_ctrl: operand forwarding and load-use stall control for a
// 5-stage pipeline. Tracks the destination of the instructions in EX, MEM
// and WB, and drives the two operand MUX selects at the end of decode.
// MUX inputs: 0 = register file, 1 = EX, 2 = MEM, 3 = WB.
// Optional feature macro: FWD_WB_BYPASS_EN. When it is defined, results
// are forwarded from WB (select 3). When it is undefined, the WB record is
// not kept, and the register file must be write-first.
module operand_fwd_ctrl #(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ID_VALID,
    input  logic [REG_AW-1:0] ID_RS1,
    input  logic [REG_AW-1:0] ID_RS2,
    input  logic              ID_RS1_USED,
    input  logic              ID_RS2_USED,
    input  logic [REG_AW-1:0] ID_RD,
    input  logic              ID_RD_WE,
    input  logic              ID_IS_LOAD,
    input  logic              FLUSH,
    output logic [SEL_W-1:0]  FWD_A_SEL,
    output logic [SEL_W-1:0]  FWD_B_SEL,
    output logic              STALL
);

    localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_EX  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(2);
`ifdef FWD_WB_BYPASS_EN
    localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(3);
`endif

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } rec_t;

    rec_t ex_q, ex_d, mem_q;
`ifdef FWD_WB_BYPASS_EN
    rec_t wb_q;
`endif

    // A record may forward only if it is real, writes a register, and that register is not x0.
    function automatic logic live(input rec_t r);
        return r.v && r.we && (r.rd != '0);
    endfunction

    // Pick the youngest producer for one source. A load still in EX yields RF
    // here, and the stall holds decode until the load reaches MEM.
    function automatic logic [SEL_W-1:0] pick_sel(
        input logic              used,
        input logic [REG_AW-1:0] rs,
        input rec_t              ex,
        input rec_t              mem,
        input logic              wb_hit
    );
        logic [SEL_W-1:0] sel;
        sel = SEL_RF;
        if (ID_VALID && used && rs != '0) begin
            if (live(ex) && ex.rd == rs)
                sel = ex.ld ? SEL_RF : SEL_EX;
            else if (live(mem) && mem.rd == rs)
                sel = SEL_MEM;
`ifdef FWD_WB_BYPASS_EN
            else if (wb_hit)
                sel = SEL_WB;
`endif
        end
        return sel;
    endfunction

    logic wb_hit_a, wb_hit_b;
    logic ex_ld_hit;

    // Forwarding selects, the load-use stall and the next EX record (all from the current records and decode).
    always_comb begin
        wb_hit_a  = 1'b0;
        wb_hit_b  = 1'b0;
`ifdef FWD_WB_BYPASS_EN
        wb_hit_a  = live(wb_q) && wb_q.rd == ID_RS1;
        wb_hit_b  = live(wb_q) && wb_q.rd == ID_RS2;
`endif
        FWD_A_SEL = pick_sel(ID_RS1_USED, ID_RS1, ex_q, mem_q, wb_hit_a);
        FWD_B_SEL = pick_sel(ID_RS2_USED, ID_RS2, ex_q, mem_q, wb_hit_b);

        ex_ld_hit = live(ex_q) && ex_q.ld &&
                    ((ID_RS1_USED && ID_RS1 == ex_q.rd) ||
                     (ID_RS2_USED && ID_RS2 == ex_q.rd));
        STALL     = ID_VALID && ex_ld_hit;

        // A flushed or stalled instruction enters EX as a bubble.
        ex_d = '0;
        if (ID_VALID && !STALL && !FLUSH) begin
            ex_d.v  = 1'b1;
            ex_d.rd = ID_RD;
            ex_d.we = ID_RD_WE;
            ex_d.ld = ID_IS_LOAD;
        end
    end

    // Record pipeline: every record moves down one stage on each clock, and reset discards all of them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_q  <= '0;
            mem_q <= '0;
`ifdef FWD_WB_BYPASS_EN
            wb_q  <= '0;
`endif
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
`ifdef FWD_WB_BYPASS_EN
            wb_q  <= mem_q;
`endif
        end
    end

    // The load flag is no longer needed once a record has left EX.
    logic unused_ld;
`ifdef FWD_WB_BYPASS_EN
    assign unused_ld = wb_q.ld;
`else
    assign unused_ld = mem_q.ld;
`endif

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Directed testbench for operand_fwd_ctrl. The bench applies inputs 1ns after
// each rising edge and samples the combinational outputs on the falling edge.
module tb_operand_fwd_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ID_VALID, ID_RS1_USED, ID_RS2_USED, ID_RD_WE, ID_IS_LOAD, FLUSH;
    logic [4:0] ID_RS1, ID_RS2, ID_RD;
    logic [1:0] FWD_A_SEL, FWD_B_SEL;
    logic       STALL;

    int vec = 0;
    int err = 0;

`ifdef FWD_WB_BYPASS_EN
    localparam logic [1:0] EXP_WB = 2'd3;
`else
    localparam logic [1:0] EXP_WB = 2'd0;
`endif

    operand_fwd_ctrl #(.REG_AW(5), .SEL_W(2)) dut (
        .CLK(CLK), .RST(RST),
        .ID_VALID(ID_VALID), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
        .ID_RD(ID_RD), .ID_RD_WE(ID_RD_WE), .ID_IS_LOAD(ID_IS_LOAD),
        .FLUSH(FLUSH),
        .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL), .STALL(STALL)
    );

    always #5 CLK = ~CLK;

    task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fl);
        ID_VALID = v;  ID_RS1 = rs1; ID_RS1_USED = u1; ID_RS2 = rs2; ID_RS2_USED = u2;
        ID_RD = rd;    ID_RD_WE = we; ID_IS_LOAD = ld; FLUSH = fl;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drv($urandom, 5'($urandom), $urandom, 5'($urandom), $urandom, 5'($urandom), $urandom, $urandom, $urandom);
        step();
        for (int i = 0; i < 2; i++) begin
            drv($urandom, 5'($urandom), $urandom, 5'($urandom), $urandom, 5'($urandom), $urandom, $urandom, 0);
            @(negedge CLK);
            vec++;
            if (FWD_A_SEL !== 2'd0 || FWD_B_SEL !== 2'd0 || STALL !== 1'b0) begin
                $display("FAIL reset[%0d] got a=%0d b=%0d stall=%0d exp a=0 b=0 stall=0", i, FWD_A_SEL, FWD_B_SEL, STALL);
                err++;
            end
            if (i == 0) step();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        RST = 1'b0;
        drain();
    endtask

    task automatic test_fwd_ex_mem_wb();
        drv(1, 0, 0, 0, 0, 5'd5, 1, 0, 0); step();   // add x5
        drv(1, 0, 0, 0, 0, 5'd6, 1, 0, 0); step();   // sub x6
        drv(1, 0, 0, 0, 0, 5'd7, 1, 0, 0); step();   // or x7
        drv(1, 5'd5, 1, 5'd7, 1, 5'd10, 0, 0, 0);
        @(negedge CLK);
        vec++;
        if (FWD_A_SEL !== EXP_WB) begin
            $display("FAIL fwd_wb_a got=%0d exp=%0d", FWD_A_SEL, EXP_WB); err++;
        end
        vec++;
        if (FWD_B_SEL !== 2'd1 || STALL !== 1'b0) begin
            $display("FAIL fwd_ex_b got b=%0d stall=%0d exp b=1 stall=0", FWD_B_SEL, STALL); err++;
        end
        ID_RS1 = 5'd6;
        #1;
        vec++;
        if (FWD_A_SEL !== 2'd2) begin
            $display("FAIL fwd_mem_a got=%0d exp=2", FWD_A_SEL); err++;
        end
        drain();
    endtask

    task automatic test_load_use();
        drv(1, 0, 0, 0, 0, 5'd8, 1, 1, 0); step();   // lw x8
        drv(1, 5'd8, 1, 5'd0, 1, 5'd10, 1, 0, 0);    // add x10, x8, x0
        @(negedge CLK);
        vec++;
        if (STALL !== 1'b1 || FWD_A_SEL !== 2'd0 || FWD_B_SEL !== 2'd0) begin
            $display("FAIL load_use_stall got stall=%0d a=%0d b=%0d exp stall=1 a=0 b=0", STALL, FWD_A_SEL, FWD_B_SEL); err++;
        end
        step();
        @(negedge CLK);
        vec++;
        if (STALL !== 1'b0 || FWD_A_SEL !== 2'd2 || FWD_B_SEL !== 2'd0) begin
            $display("FAIL load_use_release got stall=%0d a=%0d b=%0d exp stall=0 a=2 b=0", STALL, FWD_A_SEL, FWD_B_SEL); err++;
        end
        step();
        // The add itself entered EX after the stall, so a consumer now gets it from EX.
        drv(1, 0, 0, 5'd10, 1, 5'd11, 1, 0, 0);
        @(negedge CLK);
        vec++;
        if (FWD_B_SEL !== 2'd1 || STALL !== 1'b0) begin
            $display("FAIL load_use_after got b=%0d stall=%0d exp b=1 stall=0", FWD_B_SEL, STALL); err++;
        end
        drain();
    endtask

    task automatic test_priority();
        drv(1, 0, 0, 0, 0, 5'd9, 1, 0, 0); step();
        drv(1, 0, 0, 0, 0, 5'd9, 1, 0, 0); step();
        drv(1, 5'd9, 1, 5'd9, 1, 5'd12, 0, 0, 0);
        @(negedge CLK);
        vec++;
        if (FWD_A_SEL !== 2'd1 || FWD_B_SEL !== 2'd1) begin
            $display("FAIL priority_ex got a=%0d b=%0d exp a=1 b=1", FWD_A_SEL, FWD_B_SEL); err++;
        end
        ID_VALID = 1'b0;
        #1;
        vec++;
        if (FWD_A_SEL !== 2'd0 || FWD_B_SEL !== 2'd0) begin
            $display("FAIL invalid_decode got a=%0d b=%0d exp a=0 b=0", FWD_A_SEL, FWD_B_SEL); err++;
        end
        drain();
    endtask

    task automatic test_x0_unused();
        drv(1, 0, 0, 0, 0, 5'd0, 1, 0, 0); step();   // write to x0
        drv(1, 5'd0, 1, 5'd0, 1, 5'd13, 1, 0, 0);
        @(negedge CLK);
        vec++;
        if (FWD_A_SEL !== 2'd0 || FWD_B_SEL !== 2'd0 || STALL !== 1'b0) begin
            $display("FAIL x0_read got a=%0d b=%0d stall=%0d exp 0 0 0", FWD_A_SEL, FWD_B_SEL, STALL); err++;
        end
        drain();
        drv(1, 0, 0, 0, 0, 5'd4, 1, 1, 0); step();   // lw x4
        drv(1, 5'd4, 0, 5'd4, 0, 5'd14, 1, 0, 0);
        @(negedge CLK);
        vec++;
        if (STALL !== 1'b0 || FWD_A_SEL !== 2'd0 || FWD_B_SEL !== 2'd0) begin
            $display("FAIL unused_src got stall=%0d a=%0d b=%0d exp 0 0 0", STALL, FWD_A_SEL, FWD_B_SEL); err++;
        end
        drain();
    endtask

    task automatic test_flush();
        drv(1, 0, 0, 0, 0, 5'd3, 1, 1, 1); step();   // lw x3, flushed
        drv(1, 5'd3, 1, 0, 0, 5'd15, 1, 0, 0);
        @(negedge CLK);
        vec++;
        if (STALL !== 1'b0 || FWD_A_SEL !== 2'd0) begin
            $display("FAIL flush_bubble got stall=%0d a=%0d exp stall=0 a=0", STALL, FWD_A_SEL); err++;
        end
        drain();
        // Flush arrives together with a load-use stall. The stall is still reported, and a bubble enters EX.
        drv(1, 0, 0, 0, 0, 5'd8, 1, 1, 0); step();   // lw x8
        drv(1, 5'd8, 1, 0, 0, 5'd16, 1, 0, 1);
        @(negedge CLK);
        vec++;
        if (STALL !== 1'b1) begin
            $display("FAIL flush_stall got stall=%0d exp stall=1", STALL); err++;
        end
        step();
        drv(1, 5'd16, 1, 5'd8, 1, 5'd17, 0, 0, 0);
        @(negedge CLK);
        vec++;
        if (FWD_A_SEL !== 2'd0 || FWD_B_SEL !== 2'd2 || STALL !== 1'b0) begin
            $display("FAIL flush_stall_next got a=%0d b=%0d stall=%0d exp a=0 b=2 stall=0", FWD_A_SEL, FWD_B_SEL, STALL); err++;
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        drv(1, 0, 0, 0, 0, 5'd8, 1, 1, 0); step();   // lw x8
        RST = 1'b1;
        drv(1, 5'd8, 1, 0, 0, 5'd18, 1, 0, 0);
        step();
        RST = 1'b0;
        @(negedge CLK);
        vec++;
        if (STALL !== 1'b0 || FWD_A_SEL !== 2'd0) begin
            $display("FAIL reset_mid got stall=%0d a=%0d exp stall=0 a=0", STALL, FWD_A_SEL); err++;
        end
        drain();
    endtask

    initial begin
        RST = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_fwd_ex_mem_wb();
        test_load_use();
        test_priority();
        test_x0_unused();
        test_flush();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/operand_fwd_ctrl.md
Name: operand_fwd_ctrl

Overview:
- Tracks destination registers of in-flight instructions (EX, MEM, WB) with a 3-deep record pipeline.
- Drives the SEL inputs of the two operand-select MUX instances that sit directly downstream at the end of decode. Operand MUX input order: 0 = register file, 1 = EX result, 2 = MEM result, 3 = WB result.
- Detects load-use hazards and issues a decode stall.

Parameters:
- REG_AW, 5, architectural register address width (32 registers).
- SEL_W, 2, width of each forwarding select output. Must be ≥2.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous active-high reset.
- ID_VALID  input  1  decode slot holds a real instruction.
- ID_RS1  input  REG_AW  source register 1 of the decode instruction.
- ID_RS2  input  REG_AW  source register 2 of the decode instruction.
- ID_RS1_USED  input  1  instruction reads rs1.
- ID_RS2_USED  input  1  instruction reads rs2.
- ID_RD  input  REG_AW  destination register.
- ID_RD_WE  input  1  instruction writes rd.
- ID_IS_LOAD  input  1  instruction is a load.
- FLUSH  input  1  kill the decode instruction (branch redirect).
- FWD_A_SEL  output  SEL_W  operand A MUX select.
- FWD_B_SEL  output  SEL_W  operand B MUX select.
- STALL  output  1  hold PC/IF/ID this cycle and insert a bubble into EX.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Internal records EX_r, MEM_r, WB_r. Each holds {v, rd, we, ld}. A record is "live" when v && we && rd != 0.
- Reset: all records have v=0, rd=0, we=0, ld=0. FWD_A_SEL=0, FWD_B_SEL=0, STALL=0 in the cycle after reset and until a live record exists.
- Advance every clock: WB_r <= MEM_r; MEM_r <= EX_r.
- EX_r <= ID fields when ID_VALID && !STALL && !FLUSH. Otherwise EX_r <= bubble (v=0).
- FLUSH and STALL in the same cycle: bubble inserted. FLUSH takes precedence but STALL output is still reported.
- Outputs are combinational from the current records and ID inputs. Zero-cycle latency, valid in the same cycle as the ID inputs.
- Select for operand X (X = A/rs1, B/rs2), evaluated in priority order EX > MEM > WB (youngest wins):
  - !ID_VALID or !RSx_USED or RSx == 0 -> 0.
  - EX_r live and rd == RSx and !ld -> 1.
  - EX_r live and rd == RSx and ld -> 0 (stall case).
  - MEM_r live and rd == RSx -> 2. Load data is available in MEM.
  - WB_r live and rd == RSx -> 3.
  - No match -> 0.
- STALL = ID_VALID && EX_r live && EX_r.ld && ((ID_RS1_USED && ID_RS1 == EX_r.rd) || (ID_RS2_USED && ID_RS2 == EX_r.rd)).
  - A single load-use produces exactly one stall cycle. The load then moves to MEM and the select becomes 2.
- Register x0 never forwards and never stalls.
- Reset asserted mid-stream clears all records the next edge; in-flight hazards are discarded.
- Upper select codes (if SEL_W > 2) are never driven.

Optional Feature:
- Macro FWD_WB_BYPASS_EN.
- Defined: WB forwarding enabled as above (select 3).
- Undefined: the WB match is ignored and the select falls to 0. The register file must be write-first. Select 3 is never produced. WB_r may be omitted from the RTL.

Test Plan:
- Reset: hold RST 2 cycles with random ID inputs -> FWD_A_SEL=0, FWD_B_SEL=0, STALL=0.
- EX/MEM/WB forwarding, no gaps:
  - Stimulus: "add x5" (we=1), "sub x6" (we=1), "or x7" (we=1), then decode rs1=x5, rs2=x7.
  - Response: FWD_A_SEL=3, FWD_B_SEL=1 (WB/EX).
  - Repeat with rs1=x6 -> FWD_A_SEL=2.
- Load-use:
  - Stimulus: "lw x8" then "add rs1=x8, rs2=x0".
  - Response: STALL=1 for exactly 1 cycle with FWD_A_SEL=0; next cycle STALL=0, FWD_A_SEL=2, FWD_B_SEL=0.
- Priority: "addi x9", "addi x9", then decode rs1=rs2=x9 -> both selects = 1 (EX beats MEM).
- x0 and unused sources:
  - Write to x0 followed by a read of x0 -> select 0.
  - "lw x4" followed by an instruction with ID_RS1=x4 and RS1_USED=0 -> STALL=0, select 0.
- FLUSH:
  - Stimulus: "lw x3" with FLUSH=1 in decode, then "add rs1=x3".
  - Response: STALL=0, select 0 (record was bubbled).
  - With FWD_WB_BYPASS_EN undefined, rerun the EX/MEM/WB forwarding case -> FWD_A_SEL=0 instead of 3.
